// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : RISC-V MEM stage. Drives a req/ack data-memory port, stalls
//               the upstream stages while an access is outstanding, and
//               registers results into MEM/WB. Optional access abort on
//               timeout is compiled in with the MEM_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RDM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             StallM,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RDW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic             MisalignW,
    output logic             TimeoutW,
    output logic [CNT_W-1:0] WaitCount
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_load;
    logic w_mem_op;
    logic w_misalign;
    logic w_access;
    logic w_timeout;
    logic w_allow;

    assign w_load     = (ResultSrcM == 2'b01);
    assign w_mem_op   = MemWriteM | w_load;
    assign w_misalign = w_mem_op & (ALUResultM[1:0] != 2'b00);
    assign w_access   = w_mem_op & ~w_misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counter is zero whenever not stalling, so it counts stall cycles of
    // the current access only; it reaches TIMEOUT on the abort cycle.
    always_ff @(posedge clk) begin
        if (reset || !StallM) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == TMO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            TimeoutW <= 1'b0;
        end else begin
            TimeoutW <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign TimeoutW  = 1'b0;
`endif

    assign w_allow    = (r_state == S_IDLE) | ~w_timeout;
    assign dmem_req   = ~reset & w_access & w_allow;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = dmem_req & ~dmem_ack;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (StallM) w_state_next = S_WAIT;
            S_WAIT: if (!StallM) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // MEM/WB register: stalls, aborts and misaligned accesses become bubbles.
    always_ff @(posedge clk) begin
        if (reset || StallM || w_timeout || w_misalign) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RDW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            MisalignW  <= ~reset & ~StallM & w_misalign;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= (w_load && dmem_req && dmem_ack) ? dmem_rdata : '0;
            PCPlus4W   <= PCPlus4M;
            RDW        <= RDM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            MisalignW  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            WaitCount <= '0;
        end else if (StallM && (WaitCount != {CNT_W{1'b1}})) begin
            WaitCount <= WaitCount + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage; expected MEM/WB records
//               are queued per driven cycle and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RDM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        StallM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RDW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        MisalignW, TimeoutW;
    logic [3:0]  WaitCount;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic        mis;
        logic        tmo;
    } wb_t;

    wb_t sb[$];

    memory_stage #(.WIDTH(32), .TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RDM(RDM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .StallM(StallM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RDW(RDW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .MisalignW(MisalignW), .TimeoutW(TimeoutW), .WaitCount(WaitCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wb_t mk_wb(input logic [31:0] alu, input logic [31:0] rdata,
                                  input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                                  input logic [1:0] rs, input logic mis, input logic tmo);
        wb_t w;
        w.alu = alu; w.rdata = rdata; w.pc4 = pc4; w.rd = rd;
        w.rw = rw; w.rs = rs; w.mis = mis; w.tmo = tmo;
        return w;
    endfunction

    task automatic compare_wb(input string tag, input wb_t e);
        check_eq({tag, ".ALUResultW"}, 64'(ALUResultW), 64'(e.alu));
        check_eq({tag, ".ReadDataW"},  64'(ReadDataW),  64'(e.rdata));
        check_eq({tag, ".PCPlus4W"},   64'(PCPlus4W),   64'(e.pc4));
        check_eq({tag, ".RDW"},        64'(RDW),        64'(e.rd));
        check_eq({tag, ".RegWriteW"},  64'(RegWriteW),  64'(e.rw));
        check_eq({tag, ".ResultSrcW"}, 64'(ResultSrcW), 64'(e.rs));
        check_eq({tag, ".MisalignW"},  64'(MisalignW),  64'(e.mis));
        check_eq({tag, ".TimeoutW"},   64'(TimeoutW),   64'(e.tmo));
    endtask

    // One pipeline cycle: drive, check combinational port, then check MEM/WB.
    task automatic run_cycle(input string tag,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                             input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rs,
                             input logic ack, input logic [31:0] rdata,
                             input logic exp_req, input logic exp_stall, input wb_t exp_wb);
        wb_t e;
        ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RDM = rd;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        dmem_ack = ack; dmem_rdata = rdata;
        sb.push_back(exp_wb);
        #4;
        check_eq({tag, ".dmem_req"}, 64'(dmem_req), 64'(exp_req));
        check_eq({tag, ".StallM"},   64'(StallM),   64'(exp_stall));
        if (exp_req) begin
            check_eq({tag, ".dmem_addr"},  64'(dmem_addr),  64'(alu));
            check_eq({tag, ".dmem_we"},    64'(dmem_we),    64'(mw));
            check_eq({tag, ".dmem_wdata"}, 64'(dmem_wdata), 64'(wd));
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            compare_wb(tag, e);
        end
    endtask

    wb_t bub;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bub = mk_wb(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        ALUResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0; RDM = 5'd0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        compare_wb("reset", bub);
        check_eq("reset.WaitCount", 64'(WaitCount), 64'd0);
        check_eq("reset.StallM",    64'(StallM),    64'd0);
        reset = 1'b0;

        // ALU op passes through in one cycle
        run_cycle("add", 32'h1234, 32'h0, 32'h44, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  1'b0, 1'b0, mk_wb(32'h1234, 32'h0, 32'h44, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0));

        // Zero-wait load
        run_cycle("load0", 32'h100, 32'h0, 32'h48, 5'd6, 1'b1, 1'b0, 2'b01, 1'b1, 32'hDEADBEEF,
                  1'b1, 1'b0, mk_wb(32'h100, 32'hDEADBEEF, 32'h48, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0));

        // Store acked after three wait cycles
        for (int i = 0; i < 3; i++)
            run_cycle("store_wait", 32'h200, 32'hA5A5A5A5, 32'h4C, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,
                      1'b1, 1'b1, bub);
        run_cycle("store_ack", 32'h200, 32'hA5A5A5A5, 32'h4C, 5'd0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0,
                  1'b1, 1'b0, mk_wb(32'h200, 32'h0, 32'h4C, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0));
        check_eq("store.WaitCount", 64'(WaitCount), 64'd3);

        // Misaligned load: no request, flagged bubble
        run_cycle("misalign", 32'h102, 32'h0, 32'h50, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0,
                  1'b0, 1'b0, mk_wb(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0));

        // PC+4 result with a stray ack that must be ignored
        run_cycle("jal", 32'h55, 32'h0, 32'h80, 5'd1, 1'b1, 1'b0, 2'b10, 1'b1, 32'hFFFF,
                  1'b0, 1'b0, mk_wb(32'h55, 32'h0, 32'h80, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0));

        // Reset during the second wait cycle aborts the access
        run_cycle("rst_wait1", 32'h300, 32'h0, 32'h84, 5'd9, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0,
                  1'b1, 1'b1, bub);
        reset = 1'b1;
        run_cycle("rst_wait2", 32'h300, 32'h0, 32'h84, 5'd9, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0,
                  1'b0, 1'b0, bub);
        reset = 1'b0;
        check_eq("rst.WaitCount", 64'(WaitCount), 64'd0);
        run_cycle("post_rst", 32'h77, 32'h0, 32'h88, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  1'b0, 1'b0, mk_wb(32'h77, 32'h0, 32'h88, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0));

        // WaitCount saturates at 15 (4-bit) instead of wrapping
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 3; j++)
                run_cycle("sat_wait", 32'h1000 + 32'(k * 4), 32'(k), 32'h90, 5'd0, 1'b0, 1'b1, 2'b00,
                          1'b0, 32'h0, 1'b1, 1'b1, bub);
            run_cycle("sat_ack", 32'h1000 + 32'(k * 4), 32'(k), 32'h90, 5'd0, 1'b0, 1'b1, 2'b00,
                      1'b1, 32'h0, 1'b1, 1'b0,
                      mk_wb(32'h1000 + 32'(k * 4), 32'h0, 32'h90, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0));
            if (k == 4) check_eq("sat.WaitCount15", 64'(WaitCount), 64'd15);
        end
        check_eq("sat.WaitCount_hold", 64'(WaitCount), 64'd15);

`ifdef MEM_TIMEOUT_EN
        // No ack: four stall cycles, then abort with TimeoutW
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            run_cycle("tmo_wait", 32'h400, 32'h0, 32'h94, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0,
                      1'b1, 1'b1, bub);
        run_cycle("tmo_abort", 32'h400, 32'h0, 32'h94, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0,
                  1'b0, 1'b0, mk_wb(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1));
        check_eq("tmo.WaitCount", 64'(WaitCount), 64'd4);
        run_cycle("tmo_next", 32'h99, 32'h0, 32'h98, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0,
                  1'b0, 1'b0, mk_wb(32'h99, 32'h0, 32'h98, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
